// File: rtl/memory_bus_arbiter_if.sv
// Purpose : bundles the CPU, loader and RAM-side signals of the memory bus arbiter.
// Latency : none (wiring only).
// Backpr. : req/ack handshake; a requester holds req until it sees its ack.
//
// Signals
//   cpu_req/cpu_we/cpu_address/cpu_data_in -> arbiter ; cpu_data_out/cpu_ack <- arbiter
//   ldr_req/ldr_address/ldr_data           -> arbiter ; ldr_ack              <- arbiter
//   ram_address/ram_data_in/ram_write_enable <- arbiter ; ram_data_out -> arbiter
//   busy, prot_fault                       <- arbiter status
// Modports: slave = the arbiter, master = everything around it (requesters and RAM).
interface memory_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [7:0]            cpu_data_in;
  logic [7:0]            cpu_data_out;
  logic                  cpu_ack;

  logic                  ldr_req;
  logic [ADDR_WIDTH-1:0] ldr_address;
  logic [7:0]            ldr_data;
  logic                  ldr_ack;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [7:0]            ram_data_in;
  logic [7:0]            ram_data_out;
  logic                  ram_write_enable;

  logic                  busy;
  logic                  prot_fault;

  modport slave (
    input  cpu_req, cpu_we, cpu_address, cpu_data_in,
    output cpu_data_out, cpu_ack,
    input  ldr_req, ldr_address, ldr_data,
    output ldr_ack,
    output ram_address, ram_data_in, ram_write_enable,
    input  ram_data_out,
    output busy, prot_fault
  );

  modport master (
    output cpu_req, cpu_we, cpu_address, cpu_data_in,
    input  cpu_data_out, cpu_ack,
    output ldr_req, ldr_address, ldr_data,
    input  ldr_ack,
    input  ram_address, ram_data_in, ram_write_enable,
    output ram_data_out,
    input  busy, prot_fault
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Purpose : arbitrates the 8008 block RAM between the CPU (rd/wr) and the UART loader (wr only).
// Latency : write ack 1 cycle after the sampling edge, read ack READ_LATENCY+2 cycles after it.
// Backpr. : one transaction at a time; requests seen while busy wait until IDLE (no queueing).
//
// Ports
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset; abandons any transaction without an ack
//   bus      - memory_bus_arbiter_if.slave: CPU and loader handshakes, RAM port, busy, prot_fault
// Optional feature: define MEM_PROTECT_EN to block CPU writes below ROM_TOP (sticky prot_fault).
// Loader has fixed priority over the CPU. READ_LATENCY legal range is 1..7.
module memory_bus_arbiter #(
  parameter int unsigned           ADDR_WIDTH   = 14,
  parameter int unsigned           READ_LATENCY = 2,
  parameter logic [ADDR_WIDTH-1:0] ROM_TOP      = 14'h0400
) (
  input  logic                clk,
  input  logic                reset_n,
  memory_bus_arbiter_if.slave bus
);

`ifdef MEM_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    READ_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdat_q;
  logic                  we_q;
  logic [2:0]            cnt_q;
  logic                  cpu_ack_q;
  logic                  ldr_ack_q;
  logic [7:0]            rdat_q;
  logic                  busy_q;
  logic                  fault_q;

  logic ldr_win;
  logic cpu_win;
  logic wr_blocked;

  // Loader always wins; the CPU only gets the RAM on cycles the loader is quiet.
  assign ldr_win    = bus.ldr_req;
  assign cpu_win    = bus.cpu_req & ~bus.ldr_req;
  // A blocked CPU write still walks through WRITE and acks, it just never strobes the RAM.
  assign wr_blocked = PROTECT_EN && cpu_win && bus.cpu_we && (bus.cpu_address < ROM_TOP);

  // Every output comes straight from a flop, so acks and the write strobe are set on the
  // edge that enters the state in which they are visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdat_q    <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      rdat_q    <= '0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      we_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ldr_win) begin
            addr_q    <= bus.ldr_address;
            wdat_q    <= bus.ldr_data;
            we_q      <= 1'b1;
            ldr_ack_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= WRITE;
          end else if (cpu_win) begin
            addr_q <= bus.cpu_address;
            wdat_q <= bus.cpu_data_in;
            busy_q <= 1'b1;
            if (bus.cpu_we) begin
              we_q      <= ~wr_blocked;
              cpu_ack_q <= 1'b1;
              state_q   <= WRITE;
              if (wr_blocked) begin
                fault_q <= 1'b1;
              end
            end else begin
              // Counter reaches 0 after READ_LATENCY-1 decrements; READ_DONE then
              // samples the RAM exactly READ_LATENCY edges after the address went out.
              cnt_q   <= 3'(READ_LATENCY - 1);
              state_q <= READ_WAIT;
            end
          end
        end
        WRITE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        READ_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= READ_DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        READ_DONE: begin
          rdat_q    <= bus.ram_data_out;
          cpu_ack_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_address      = addr_q;
  assign bus.ram_data_in      = wdat_q;
  assign bus.ram_write_enable = we_q;
  assign bus.cpu_ack          = cpu_ack_q;
  assign bus.ldr_ack          = ldr_ack_q;
  assign bus.cpu_data_out     = rdat_q;
  assign bus.busy             = busy_q;
  assign bus.prot_fault       = fault_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Purpose : directed self-checking bench for memory_bus_arbiter with a 2-cycle RAM model.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : requesters hold req until their ack, then drop it.
module tb_memory_bus_arbiter;
  localparam int unsigned AW = 14;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  memory_bus_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  memory_bus_arbiter #(
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(RL),
    .ROM_TOP     (14'h0400)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Block RAM with two registered read stages (READ_LATENCY = 2).
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rd1;
  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_in;
    rd1              <= mem[bus.ram_address];
    bus.ram_data_out <= rd1;
  end

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7) + 8'h3C);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one CPU read; lat is the cycle of the ack after the sampling edge, 0 on timeout.
  task automatic cpu_read(input logic [AW-1:0] a, output logic [7:0] d, output int lat);
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b0;
    bus.cpu_address = a;
    lat = 0;
    d   = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.cpu_ack === 1'b1) begin
        lat = i;
        d   = bus.cpu_data_out;
        break;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    int acks;
    reset_n         = 1'b0;
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_data_in = '0;
    bus.ldr_req     = 1'b0;
    bus.ldr_address = '0;
    bus.ldr_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.cpu_ack, bus.ldr_ack, bus.ram_write_enable, bus.busy, bus.prot_fault} !== 5'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 00000",
        {bus.cpu_ack, bus.ldr_ack, bus.ram_write_enable, bus.busy, bus.prot_fault}); end
    checks++;
    if ({bus.ram_address, bus.ram_data_in, bus.cpu_data_out} !== '0)
      begin errors++; $display("FAIL reset_bus: addr=%h din=%h dout=%h want all 0",
        bus.ram_address, bus.ram_data_in, bus.cpu_data_out); end
    reset_n = 1'b1;
    tick();

    // Reset in the middle of READ_WAIT.
    bus.cpu_req     = 1'b1;
    bus.cpu_address = 14'h0020;
    tick();
    checks++;
    if (bus.busy !== 1'b1)
      begin errors++; $display("FAIL reset_pre_busy: got %b want 1", bus.busy); end
    #2;
    reset_n     = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.cpu_ack, bus.ram_address} !== '0)
      begin errors++; $display("FAIL reset_mid_read: busy=%b ack=%b addr=%h want 0",
        bus.busy, bus.cpu_ack, bus.ram_address); end
    tick();
    tick();
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.cpu_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0)
      begin errors++; $display("FAIL reset_no_ack: got %0d acks want 0", acks); end

    // Reset during WRITE drops the strobe without waiting for a clock.
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.cpu_address = 14'h0555;
    bus.cpu_data_in = 8'h77;
    tick();
    #2;
    reset_n     = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    checks++;
    if (bus.ram_write_enable !== 1'b0)
      begin errors++; $display("FAIL reset_async_we: got %b want 0", bus.ram_write_enable); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write();
    int we_cnt;
    int ack_cnt;
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.cpu_address = 14'h0123;
    bus.cpu_data_in = 8'h5A;
    tick();
    checks++;
    if (!(bus.ram_write_enable === 1'b1 && bus.ram_address === 14'h0123 && bus.ram_data_in === 8'h5A))
      begin errors++; $display("FAIL wr_strobe: we=%b addr=%h din=%h want 1/0123/5a",
        bus.ram_write_enable, bus.ram_address, bus.ram_data_in); end
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.ldr_ack !== 1'b0)
      begin errors++; $display("FAIL wr_ack: cpu_ack=%b ldr_ack=%b want 1/0", bus.cpu_ack, bus.ldr_ack); end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    we_cnt  = 0;
    ack_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ram_write_enable === 1'b1) we_cnt++;
      if (bus.cpu_ack === 1'b1) ack_cnt++;
    end
    checks++;
    if (we_cnt != 0 || ack_cnt != 0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL wr_single_cycle: extra we=%0d acks=%0d busy=%b want 0/0/0",
        we_cnt, ack_cnt, bus.busy); end
  endtask

  task automatic test_cpu_read();
    int         ack_cyc;
    int         ack_cnt;
    int         hold_bad;
    logic [7:0] d;
    ack_cyc  = 0;
    ack_cnt  = 0;
    hold_bad = 0;
    d        = 8'h00;
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b0;
    bus.cpu_address = 14'h0123;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c < 4 && (bus.ram_address !== 14'h0123 || bus.busy !== 1'b1 || bus.ram_write_enable !== 1'b0))
        hold_bad++;
      if (bus.cpu_ack === 1'b1) begin
        if (ack_cyc == 0) ack_cyc = c;
        ack_cnt++;
        d = bus.cpu_data_out;
        bus.cpu_req = 1'b0;
      end
    end
    checks++;
    if (ack_cyc != 4)
      begin errors++; $display("FAIL rd_latency: ack in cycle %0d want 4", ack_cyc); end
    checks++;
    if (ack_cnt != 1)
      begin errors++; $display("FAIL rd_ack_count: got %0d want 1", ack_cnt); end
    checks++;
    if (d !== 8'h5A)
      begin errors++; $display("FAIL rd_data: got %h want 5a", d); end
    checks++;
    if (hold_bad != 0)
      begin errors++; $display("FAIL rd_addr_hold: %0d bad cycles want 0", hold_bad); end
    checks++;
    if (bus.cpu_data_out !== 8'h5A)
      begin errors++; $display("FAIL rd_data_held: got %h want 5a", bus.cpu_data_out); end
  endtask

  task automatic test_simultaneous();
    int         ldr_cyc;
    int         cpu_cyc;
    logic [7:0] d;
    ldr_cyc = 0;
    cpu_cyc = 0;
    d       = 8'h00;
    bus.ldr_req     = 1'b1;
    bus.ldr_address = 14'h0010;
    bus.ldr_data    = 8'hC3;
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b0;
    bus.cpu_address = 14'h0010;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.ldr_ack === 1'b1 && ldr_cyc == 0) begin
        ldr_cyc     = c;
        bus.ldr_req = 1'b0;
      end
      if (bus.cpu_ack === 1'b1 && cpu_cyc == 0) begin
        cpu_cyc     = c;
        d           = bus.cpu_data_out;
        bus.cpu_req = 1'b0;
      end
    end
    checks++;
    if (ldr_cyc != 1)
      begin errors++; $display("FAIL sim_ldr_first: ldr_ack cycle %0d want 1", ldr_cyc); end
    checks++;
    if (cpu_cyc != 6)
      begin errors++; $display("FAIL sim_cpu_after: cpu_ack cycle %0d want 6", cpu_cyc); end
    checks++;
    if (d !== 8'hC3)
      begin errors++; $display("FAIL sim_rd_data: got %h want c3", d); end
  endtask

  task automatic test_loader_stream();
    int         n;
    int         last;
    int         gap_bad;
    int         stray;
    int         bad;
    int         first_bad;
    int         lat;
    logic [7:0] d;
    n       = 0;
    last    = 0;
    gap_bad = 0;
    stray   = 0;
    bus.ldr_req     = 1'b1;
    bus.ldr_address = '0;
    bus.ldr_data    = pat(0);
    for (int c = 1; c <= 700 && n < 256; c++) begin
      tick();
      if (bus.cpu_ack === 1'b1) stray++;
      if (bus.ldr_ack === 1'b1) begin
        if ((n == 0 && c != 1) || (n > 0 && c - last != 2)) gap_bad++;
        last = c;
        n++;
        if (n == 256) begin
          bus.ldr_req = 1'b0;
        end else begin
          bus.ldr_address = AW'(n);
          bus.ldr_data    = pat(n);
        end
      end
    end
    bus.ldr_req = 1'b0;
    checks++;
    if (n != 256)
      begin errors++; $display("FAIL ldr_count: got %0d acks want 256", n); end
    checks++;
    if (gap_bad != 0 || stray != 0)
      begin errors++; $display("FAIL ldr_rate: %0d bad gaps, %0d cpu acks want 0/0", gap_bad, stray); end
    tick();
    bad       = 0;
    first_bad = -1;
    for (int a = 0; a < 256; a++) begin
      cpu_read(AW'(a), d, lat);
      if (lat != 4 || d !== pat(a)) begin
        bad++;
        if (first_bad < 0) first_bad = a;
      end
    end
    checks++;
    if (bad != 0)
      begin errors++; $display("FAIL ldr_readback: %0d bad (first at %0d) want 0", bad, first_bad); end
  endtask

  task automatic test_protect();
    logic       exp_we;
    logic       exp_fault;
    logic [7:0] exp_dat;
    logic [7:0] d;
    int         lat;
`ifdef MEM_PROTECT_EN
    exp_we    = 1'b0;
    exp_fault = 1'b1;
    exp_dat   = pat(16'h0010);
`else
    exp_we    = 1'b1;
    exp_fault = 1'b0;
    exp_dat   = 8'hFF;
`endif
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.cpu_address = 14'h0010;
    bus.cpu_data_in = 8'hFF;
    tick();
    checks++;
    if (bus.cpu_ack !== 1'b1)
      begin errors++; $display("FAIL prot_ack: got %b want 1", bus.cpu_ack); end
    checks++;
    if (bus.ram_write_enable !== exp_we)
      begin errors++; $display("FAIL prot_we: got %b want %b", bus.ram_write_enable, exp_we); end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.prot_fault !== exp_fault)
      begin errors++; $display("FAIL prot_fault: got %b want %b", bus.prot_fault, exp_fault); end
    cpu_read(14'h0010, d, lat);
    checks++;
    if (d !== exp_dat || lat != 4)
      begin errors++; $display("FAIL prot_readback: got %h lat %0d want %h lat 4", d, lat, exp_dat); end

    // First writable address goes through and the fault flag stays as it was.
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.cpu_address = 14'h0400;
    bus.cpu_data_in = 8'h99;
    tick();
    checks++;
    if (bus.ram_write_enable !== 1'b1 || bus.cpu_ack !== 1'b1)
      begin errors++; $display("FAIL prot_top_write: we=%b ack=%b want 1/1", bus.ram_write_enable, bus.cpu_ack); end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    cpu_read(14'h0400, d, lat);
    checks++;
    if (d !== 8'h99 || bus.prot_fault !== exp_fault)
      begin errors++; $display("FAIL prot_sticky: data=%h fault=%b want 99/%b", d, bus.prot_fault, exp_fault); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_simultaneous();
    test_loader_stream();
    test_protect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
